// File: rtl/dpa_pkg.sv
// Shared types, geometry constants and glyph selection for the DPA time overlay.
package dpa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DRAW,
    ST_DONE
  } osd_state_t;

  localparam int GLYPH_W     = 16;
  localparam int GLYPH_H     = 32;
  localparam int N_CHARS     = 8;
  localparam int FB_ROW_LOG2 = 8;

  localparam logic [3:0] CODE_COLON   = 4'd10;
  localparam logic [3:0] CODE_INVALID = 4'd15;

  // ROM code for one character slot plus a flag marking a non-BCD digit.
  typedef struct packed {
    logic       invalid;
    logic [3:0] code;
  } glyph_sel_t;

  // Maps character slot 0..7 of "HH:MM:SS" to its ROM code.
  function automatic glyph_sel_t glyph_sel(input logic [23:0] t, input logic [2:0] ch);
    logic [3:0] nib;
    glyph_sel_t sel;
    nib         = 4'd0;
    sel.invalid = 1'b0;
    sel.code    = CODE_COLON;
    case (ch)
      3'd0:    nib = t[23:20];
      3'd1:    nib = t[19:16];
      3'd3:    nib = t[15:12];
      3'd4:    nib = t[11:8];
      3'd6:    nib = t[7:4];
      3'd7:    nib = t[3:0];
      default: nib = 4'd0;
    endcase
    if (ch != 3'd2 && ch != 3'd5) begin
      if (nib > 4'd9) begin
        sel.invalid = 1'b1;
        sel.code    = CODE_INVALID;
      end else begin
        sel.code = nib;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/osd_row_sr.sv
// Glyph-row shifter: holds one 16-pixel ROM row and walks its columns.
// The stored row is kept one pixel ahead, so `pix` is always the pixel that
// the next registered write decision needs (din's MSB while loading).
module osd_row_sr
  import dpa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [GLYPH_W-1:0] din,
  output logic               pix,
  output logic [3:0]         col,
  output logic               last
);

  logic [GLYPH_W-1:0] sr_q;
  logic [3:0]         col_q;

  // Load a fresh row (already advanced by one pixel) or shift one column left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q  <= '0;
      col_q <= 4'd0;
    end else if (load) begin
      sr_q  <= {din[GLYPH_W-2:0], 1'b0};
      col_q <= 4'd0;
    end else if (shift) begin
      sr_q  <= {sr_q[GLYPH_W-2:0], 1'b0};
      col_q <= col_q + 4'd1;
    end
  end

  assign pix  = load ? din[GLYPH_W-1] : sr_q[GLYPH_W-1];
  assign col  = col_q;
  assign last = (col_q == 4'd15);

endmodule

// File: rtl/time_osd.sv
// Time-of-day overlay: renders "HH:MM:SS" glyphs from the character ROM into
// the frame buffer, writing only foreground pixels so the photo shows through.
module time_osd
  import dpa_pkg::*;
#(
  parameter int          ORG_X    = 64,
  parameter int          ORG_Y    = 112,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] curr_time,
  input  logic [19:0] fb_addr,
  output logic [8:0]  cr_a,
  input  logic [15:0] cr_q,
  output logic [19:0] im_a,
  output logic        im_wen_n,
  output logic [23:0] im_d,
  output logic        busy,
  output logic        done
);

  osd_state_t  state_q;
  logic [23:0] time_q;
  logic [2:0]  ch_q;
  logic [4:0]  row_q;
  logic        inv_q;
  logic [8:0]  cr_a_q;
  logic [19:0] im_a_q;
  logic        im_wen_n_q;
  logic        busy_q;
  logic        done_q;

  logic        sr_load;
  logic        sr_shift;
  logic        sr_pix;
  logic        sr_last;
  logic [3:0]  sr_col;

  glyph_sel_t  first_sel;
  glyph_sel_t  cur_sel;
  glyph_sel_t  next_sel;
  logic        row_last;
  logic        ch_last;
  logic [19:0] addr_first;
  logic [19:0] addr_next;

  // Frame-buffer word address of pixel (ch, row, col); wraps in 20 bits.
  function automatic logic [19:0] pix_addr(input logic [19:0] base, input logic [2:0] ch,
                                           input logic [4:0] row, input logic [3:0] col);
    logic [19:0] x;
    logic [19:0] y;
    x = 20'(ORG_X) + 20'({ch, col});
    y = 20'(ORG_Y) + 20'(row);
    return base + (y << FB_ROW_LOG2) + x;
  endfunction

  assign first_sel  = glyph_sel(curr_time, 3'd0);
  assign cur_sel    = glyph_sel(time_q, ch_q);
  assign next_sel   = glyph_sel(time_q, ch_q + 3'd1);
  assign row_last   = (row_q == 5'(GLYPH_H - 1));
  assign ch_last    = (ch_q == 3'(N_CHARS - 1));
  assign addr_first = pix_addr(fb_addr, ch_q, row_q, 4'd0);
  assign addr_next  = pix_addr(fb_addr, ch_q, row_q, sr_col + 4'd1);

  assign sr_load  = (state_q == ST_LATCH);
  assign sr_shift = (state_q == ST_DRAW);

  osd_row_sr u_row_sr (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (cr_q),
    .pix   (sr_pix),
    .col   (sr_col),
    .last  (sr_last)
  );

  // Render sequencer: counters, ROM address and registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      ch_q       <= '0;
      row_q      <= '0;
      inv_q      <= 1'b0;
      cr_a_q     <= '0;
      im_a_q     <= '0;
      im_wen_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          im_wen_n_q <= 1'b1;
          done_q     <= 1'b0;
          if (start) begin
            time_q  <= curr_time;
            ch_q    <= 3'd0;
            row_q   <= 5'd0;
            inv_q   <= first_sel.invalid;
            cr_a_q  <= {first_sel.code, 5'd0};
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          // Column 0 decision comes straight from the ROM data being latched.
          im_a_q     <= addr_first;
          im_wen_n_q <= ~(sr_pix & ~inv_q);
          state_q    <= ST_DRAW;
        end
        ST_DRAW: begin
          if (!sr_last) begin
            im_a_q     <= addr_next;
            im_wen_n_q <= ~(sr_pix & ~inv_q);
          end else begin
            im_wen_n_q <= 1'b1;
            if (!row_last) begin
              row_q   <= row_q + 5'd1;
              inv_q   <= cur_sel.invalid;
              cr_a_q  <= {cur_sel.code, row_q + 5'd1};
              state_q <= ST_FETCH;
            end else if (!ch_last) begin
              ch_q    <= ch_q + 3'd1;
              row_q   <= 5'd0;
              inv_q   <= next_sel.invalid;
              cr_a_q  <= {next_sel.code, 5'd0};
              state_q <= ST_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cr_a     = cr_a_q;
  assign im_a     = im_a_q;
  assign im_wen_n = im_wen_n_q;
  assign im_d     = FG_COLOR;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_time_osd.sv
// Scoreboard bench for time_osd: a reference model expands each render into
// expected ROM fetches and pixel writes; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_time_osd;

  localparam int          ORG_X      = 64;
  localparam int          ORG_Y      = 112;
  localparam logic [23:0] FG         = 24'hFFFFFF;
  localparam int          ROW_CYC    = 18;
  localparam int          RENDER_CYC = 4608;

  typedef struct {
    int          cyc;
    logic [19:0] addr;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] curr_time;
  logic [19:0] fb_addr;
  logic [8:0]  cr_a;
  logic [15:0] cr_q = 16'h0000;
  logic [19:0] im_a;
  logic        im_wen_n;
  logic [23:0] im_d;
  logic        busy;
  logic        done;

  logic [15:0] rom_mem [512];

  wr_t         wq[$];
  logic [8:0]  aq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          k = 0;
  bit          active = 1'b0;
  bit          rst_seen = 1'b0;
  int          writes_seen = 0;
  int          exp_writes = 0;

  time_osd #(.ORG_X(ORG_X), .ORG_Y(ORG_Y), .FG_COLOR(FG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .curr_time (curr_time),
    .fb_addr   (fb_addr),
    .cr_a      (cr_a),
    .cr_q      (cr_q),
    .im_a      (im_a),
    .im_wen_n  (im_wen_n),
    .im_d      (im_d),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Character ROM with one cycle of read latency.
  always @(posedge clk) cr_q <= rom_mem[cr_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every ROM fetch and every foreground pixel of "HH:MM:SS".
  task automatic push_expected(input logic [23:0] t, input logic [19:0] fb);
    int dsel [8] = '{5, 4, -1, 3, 2, -1, 1, 0};
    exp_writes = 0;
    for (int ch = 0; ch < 8; ch++) begin
      int code;
      bit inv;
      if (dsel[ch] < 0) begin
        code = 10;
        inv  = 1'b0;
      end else begin
        code = int'((t >> (4 * dsel[ch])) & 24'hF);
        inv  = (code > 9);
        if (inv) code = 15;
      end
      for (int row = 0; row < 32; row++) begin
        logic [8:0]  a;
        logic [15:0] g;
        a = 9'(code * 32 + row);
        aq.push_back(a);
        g = rom_mem[a];
        for (int col = 0; col < 16; col++) begin
          if (!inv && g[15 - col]) begin
            wr_t e;
            e.cyc  = 3 + ROW_CYC * (ch * 32 + row) + col;
            e.addr = 20'(int'(fb) + (ORG_Y + row) * 256 + ORG_X + 16 * ch + col);
            wq.push_back(e);
            exp_writes++;
          end
        end
      end
    end
  endtask

  // Monitor, edge side: follow reset and accepted starts.
  always @(posedge clk) begin
    if (!reset) begin
      active   = 1'b0;
      rst_seen = 1'b1;
      wq.delete();
      aq.delete();
    end else if (start && !active) begin
      active      = 1'b1;
      k           = 0;
      writes_seen = 0;
    end
  end

  // Monitor, sampling side: compare DUT outputs mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst_seen) begin
      rst_seen = 1'b0;
      check("rst_cr_a", 32'(cr_a), 32'h0);
      check("rst_im_a", 32'(im_a), 32'h0);
      check("rst_im_wen_n", 32'(im_wen_n), 32'h1);
      check("rst_im_d", 32'(im_d), 32'(FG));
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
    end
    if (active) k++;
    if (im_wen_n === 1'b0) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write to %0h at cycle %0d, expected none", im_a, k);
      end else begin
        e = wq.pop_front();
        check("write_addr", 32'(im_a), 32'(e.addr));
        check("write_cycle", 32'(k), 32'(e.cyc));
        check("write_data", 32'(im_d), 32'(FG));
        writes_seen++;
      end
    end
    if (active) begin
      if (k <= RENDER_CYC && (k - 1) % ROW_CYC == 0) begin
        if (aq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_extra: got cr_a %0h at cycle %0d, expected no fetch", cr_a, k);
        end else begin
          check("fetch_cr_a", 32'(cr_a), 32'(aq.pop_front()));
        end
      end
      if (k == 1) check("busy_start", 32'(busy), 32'h1);
      if (k == RENDER_CYC + 1) begin
        check("done_pulse", 32'(done), 32'h1);
        check("busy_at_done", 32'(busy), 32'h1);
      end else if (done !== 1'b0) begin
        check("done_cycle", 32'(k), 32'(RENDER_CYC + 1));
      end
      if (k == RENDER_CYC + 2) begin
        check("busy_end", 32'(busy), 32'h0);
        check("write_count", 32'(writes_seen), 32'(exp_writes));
        check("writes_left", 32'(wq.size()), 32'h0);
        check("fetches_left", 32'(aq.size()), 32'h0);
        active = 1'b0;
      end
    end else if (done !== 1'b0 && reset === 1'b1) begin
      check("done_idle", 32'(done), 32'h0);
    end
  end

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 512; i++) rom_mem[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) rom_mem[i] = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < RENDER_CYC + 200) begin
      @(negedge clk);
      n++;
    end
    if (active) begin
      n_checks++;
      n_fail++;
      $display("FAIL render_timeout: got still active after %0d cycles, expected %0d", n, RENDER_CYC + 2);
      active = 1'b0;
    end
  endtask

  task automatic issue(input logic [23:0] t, input logic [19:0] fb);
    @(negedge clk);
    curr_time = t;
    fb_addr   = fb;
    push_expected(t, fb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic render(input logic [23:0] t, input logic [19:0] fb);
    issue(t, fb);
    wait_idle();
    $display("render time=%06h fb=%05h writes=%0d expected=%0d", t, fb, writes_seen, exp_writes);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    curr_time = 24'h0;
    fb_addr   = 20'h0;
    fill_const(16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fill_const(16'h8001);
    render(24'h123456, 20'h10000);

    fill_rand();
    render(24'h235959, 20'h10000);

    fill_const(16'hFFFF);
    render(24'h1A0000, 20'h10000);

    // Re-pulsed start and changing time while busy must not matter.
    fill_rand();
    issue(24'h094512, 20'h20000);
    repeat (98) @(negedge clk);
    start     = 1'b1;
    curr_time = 24'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (1500) @(negedge clk);
    curr_time = 24'($urandom);
    wait_idle();
    $display("render time=094512 fb=20000 with noise writes=%0d expected=%0d", writes_seen, exp_writes);

    // Reset in the middle of a render, then a complete render.
    fill_const(16'hFFFF);
    issue(24'h111111, 20'h30000);
    repeat (1998) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("render time=111111 fb=30000 aborted by reset");
    fill_rand();
    render(24'h075833, 20'h30000);

    fill_const(16'h0000);
    render(24'h000000, 20'h00000);

    fill_rand();
    render(24'($urandom), 20'hFFF00);
    for (int i = 0; i < 2; i++) begin
      fill_rand();
      render(24'($urandom), 20'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_osd.md
# time_osd

Time-of-day overlay engine for the DPA device. When the controller enters its time phase, this block reads the BCD time (`HH:MM:SS`), fetches 16×32 glyph rows from the character ROM, and writes foreground pixels into the 256×256 frame buffer in image memory. It runs after the photo-scaling pass has filled the frame buffer. Background pixels are left untouched, so the time appears transparently on top of the photo.

## Interface

Parameters:
- `ORG_X`, default 64: left pixel column of the first glyph. Requires `ORG_X + 128 <= 256`.
- `ORG_Y`, default 112: top pixel row of the glyphs. Requires `ORG_Y + 32 <= 256`.
- `FG_COLOR`, default 24'hFFFFFF: pixel value written for each set glyph bit.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle request to render; sampled only in IDLE.
- `curr_time`  in  24: BCD `{H1,H0,M1,M0,S1,S0}`, one nibble per digit.
- `fb_addr`  in  20: frame-buffer base word address.
- `cr_a`  out  9: character-ROM address, `{code[3:0], row[4:0]}`.
- `cr_q`  in  16: ROM row data, valid the cycle after `cr_a`; bit 15 is the leftmost pixel.
- `im_a`  out  20: image-memory write address.
- `im_wen_n`  out  1: write enable, active low.
- `im_d`  out  24: write data; always `FG_COLOR`.
- `busy`  out  1: high while rendering.
- `done`  out  1: one-cycle pulse when rendering completes.

## Operation

- States: IDLE → FETCH → LATCH → DRAW(×16) → FETCH … → DONE → IDLE.
- IDLE:
  - On `start=1`, snapshot `curr_time` into an internal register.
  - Clear the character index `ch` (0–7) and row index `row` (0–31).
  - Go to FETCH.
- Character order:
  - `ch` 0..7 renders H1, H0, colon, M1, M0, colon, S1, S0.
  - Colon uses code 10. Digits use code = nibble value.
- FETCH:
  - Drive `cr_a = {code, row}`.
  - A digit nibble greater than 9 is fetched as code 15 and flagged invalid.
- LATCH: load `cr_q` into a 16-bit shift register; set column `col=0`.
- DRAW, one pixel per cycle, for `col` 0..15:
  - Pixel x = `ORG_X + 16*ch + col`; y = `ORG_Y + row`.
  - `im_a = fb_addr + {y,8'b0} + x`, computed in 20 bits; wraps modulo 2^20.
  - `im_wen_n = 0` only when the current MSB is 1 and the character is not invalid; otherwise 1.
  - Shift the register left each cycle.
- After `col=15`:
  - If `row<31`: `row++`, go to FETCH.
  - Else if `ch<7`: `ch++`, `row=0`, go to FETCH.
  - Else: go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `busy` is 1 in every state except IDLE.
- `start` while busy is ignored. `curr_time` changes during a render are ignored because the snapshot is used.
- Reset mid-render:
  - Return to IDLE on the next edge with all outputs at reset values.
  - No partial-write pulse is allowed.

## Timing

- Reset values: `cr_a=0`, `im_a=0`, `im_wen_n=1`, `im_d=FG_COLOR`, `busy=0`, `done=0`, state IDLE.
- All outputs are registered.
- Each row takes 18 cycles (FETCH 1, LATCH 1, DRAW 16).
- A full render takes 8×32×18 = 4608 cycles.
- With `start` sampled at edge 0:
  - FETCH occupies cycle 1.
  - The first possible write is in cycle 3.
  - The last DRAW is in cycle 4608.
  - `done=1` and `busy=1` in cycle 4609.
  - `busy=0` from cycle 4610.
- ROM latency is exactly one cycle. The block never issues back-to-back `cr_a` changes within a row.

## Structure

- Shared package `dpa_pkg` holds:
  - State enum.
  - `GLYPH_W=16`, `GLYPH_H=32`, `N_CHARS=8`, `FB_ROW_LOG2=8`.
  - `CODE_COLON=4'd10`, `CODE_INVALID=4'd15`.
- One sub-module, `osd_row_sr`: a 16-bit loadable left-shift register with a 4-bit column counter and a `last` flag.
- The FSM, counters, and address adder stay in `time_osd`.

## Test plan

- Basic address check:
  - Stimulus: `fb_addr=20'h10000`, `curr_time=24'h123456`, `cr_q=16'h8001` for all rows, `start`.
  - First `cr_a` is 9'h020.
  - First writes go to 20'h17040 and 20'h1704F.
  - Exactly 512 writes occur, and `done` pulses in cycle 4609.
- Character sequence: `curr_time=24'h235959`.
  - `cr_a` code sequence across characters is 2, 3, 10, 5, 9, 10, 5, 9.
  - Each code is held through rows 0–31.
- Invalid digit: `curr_time=24'h1A0000`, `cr_q=16'hFFFF`.
  - Character 1 is fetched with code 15.
  - Zero writes occur for x in 80–95; total writes = 7×32×16 = 3584.
- Ignored inputs and timing:
  - `start` re-pulsed at cycle 100, and `curr_time` changed mid-render.
  - Neither affects output; total duration is unchanged.
- Reset mid-render: `reset=0` at cycle 2000.
  - Next cycle: `im_wen_n=1`, `busy=0`, `cr_a=0`.
  - A new `start` afterward produces a full, correct render.
- All-zero glyphs: `cr_q=16'h0000`.
  - `im_wen_n` stays 1 for the whole render; `done` still pulses in cycle 4609.
